// File: rtl/serial_pkg.sv
// Shared definitions for the serial bit source.
// State encoding and counter width helper.
package serial_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } state_t;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_bit_source_hold.sv
// One-entry holding register with full flag.
// A write in the same cycle as a read keeps it full.
module word_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd,
  output logic             o_full,
  output logic [WIDTH-1:0] o_rd_data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // Capture a word on write; drop the flag on read-only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else begin
      if (i_wr) begin
        r_data <= i_wr_data;
      end
      if (i_wr) begin
        r_full <= 1'b1;
      end else if (i_rd) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_full    = r_full;
  assign o_rd_data = r_data;

endmodule

// File: rtl/serial_bit_source.sv
// Parallel-to-serial word source with a one-word hold.
// Back-to-back words leave no idle bit between them.
module serial_bit_source
  import serial_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sh;
  logic             r_ser;
  logic             r_fs;

  state_t           w_state;
  logic [CNT_W-1:0] w_cnt;
  logic [WIDTH-1:0] w_sh;
  logic             w_ser;
  logic             w_fs;
  logic             w_acc;
  logic             w_wr;
  logic             w_rd;
  logic             w_full;
  logic [WIDTH-1:0] w_hold;
  logic             w_load;
  logic [WIDTH-1:0] w_ld_word;
  logic [WIDTH-1:0] w_shifted;

  function automatic logic first_bit(
    input logic [WIDTH-1:0] d
  );
    return (MSB_FIRST != 0) ? d[WIDTH-1] : d[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(
    input logic [WIDTH-1:0] d
  );
    return (MSB_FIRST != 0) ?
      {d[WIDTH-2:0], 1'b0} :
      {1'b0, d[WIDTH-1:1]};
  endfunction

  assign in_ready  = !w_full && !rst;
  assign w_acc     = in_valid && in_ready;
  assign w_shifted = shift_word(r_sh);

  word_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (w_wr),
    .i_wr_data (in_data),
    .i_rd      (w_rd),
    .o_full    (w_full),
    .o_rd_data (w_hold)
  );

  // Next state: shift mid-word, else reload from hold/input or idle.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_sh      = r_sh;
    w_ser     = r_ser;
    w_fs      = 1'b0;
    w_wr      = 1'b0;
    w_rd      = 1'b0;
    w_load    = 1'b0;
    w_ld_word = w_hold;
    if (r_state == S_SHIFT && r_cnt != LAST) begin
      w_sh  = w_shifted;
      w_ser = first_bit(w_shifted);
      w_cnt = r_cnt + 1'b1;
      w_wr  = w_acc;
    end else if (w_full) begin
      w_load = 1'b1;
      w_rd   = 1'b1;
      w_wr   = w_acc;
    end else if (w_acc) begin
      w_load    = 1'b1;
      w_ld_word = in_data;
    end else begin
      w_state = S_IDLE;
      w_ser   = IDLE_LEVEL;
    end
    if (w_load) begin
      w_state = S_SHIFT;
      w_cnt   = '0;
      w_sh    = w_ld_word;
      w_ser   = first_bit(w_ld_word);
      w_fs    = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_ser   <= IDLE_LEVEL;
      r_fs    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_sh    <= w_sh;
      r_ser   <= w_ser;
      r_fs    <= w_fs;
    end
  end

  assign ser_out     = r_ser;
  assign ser_valid   = (r_state == S_SHIFT);
  assign frame_start = r_fs;
  assign busy        = (r_state == S_SHIFT) || w_full;

endmodule
